// File: rtl/mc_pkg.sv
// Shared encodings for the memory controller: command codes, default widths, FSM states.
// Imported by the interface, the controller and its RAM.
package mc_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 6;
   localparam int LEN_W      = 6;

   typedef enum logic [2:0] {
      COND_NONE  = 3'b000,
      COND_STORE = 3'b100,
      COND_XFER  = 3'b010,
      COND_PROC  = 3'b001
   } cond_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      STORE    = 3'd1,
      RD_A     = 3'd2,
      RD_B     = 3'd3,
      XFER_END = 3'd4
   } state_e;

endpackage

// File: rtl/mc_if.sv
// Command/data bundle between the sequencer (master) and the memory controller (slave).
// No flow control: commands are level-coded and start on a change of value.
interface mc_if
   import mc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [2:0]        ctrl_data_contition;
   logic [LEN_W-1:0]  mc_data_length;
   logic [DATA_W-1:0] mc_data_in;
   logic              mc_data_in_valid;
   logic              procc_done;
   logic              mc_done;
   logic              mc_data_done;
   logic [DATA_W-1:0] mc_operand_a;
   logic [DATA_W-1:0] mc_operand_b;

   modport master (
      output ctrl_data_contition, mc_data_length, mc_data_in, mc_data_in_valid, procc_done,
      input  mc_done, mc_data_done, mc_operand_a, mc_operand_b
   );

   modport slave (
      input  ctrl_data_contition, mc_data_length, mc_data_in, mc_data_in_valid, procc_done,
      output mc_done, mc_data_done, mc_operand_a, mc_operand_b
   );

endinterface

// File: rtl/mc_mem.sv
// Single-port RAM, synchronous write and read, contents survive reset.
// Read latency 1 cycle; no backpressure.
module mc_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              mc_clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_array [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = mem_array[addr];
   end

   always_ff @(posedge mc_clk) begin
      if (we) begin
         mem_array[addr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/memory_controller.sv
// Stores a data set into RAM and hands it out two words at a time as operand pairs.
// Store: mc_done 1 cycle after last write; transfer: mc_done 3 cycles after command; no backpressure.
module memory_controller
   import mc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic mc_clk,
   input logic mc_reset,
   mc_if.slave bus
);
   // One extra bit so rd_ptr+2 cannot wrap before saturating to len_q.
   localparam int PTR_W = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [2:0]        cond_q, cond_d;
   logic [PTR_W-1:0]  len_q, len_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              exhausted_q, exhausted_d;
   logic              mc_done_q, mc_done_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              cmd_edge;
   logic              abort;
   logic [PTR_W-1:0]  rd_ptr_p1, rd_ptr_p2;

   assign cmd_edge  = (bus.ctrl_data_contition != cond_q);
   assign abort     = (state_q != IDLE) && (bus.ctrl_data_contition == COND_NONE);
   assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
   assign rd_ptr_p2 = rd_ptr_q + PTR_W'(2);

   mc_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .mc_clk (mc_clk),
      .we     (mem_we),
      .addr   (mem_addr),
      .wdata  (bus.mc_data_in),
      .rdata  (mem_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cond_d      = bus.ctrl_data_contition;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      exhausted_d = exhausted_q;
      mc_done_d   = 1'b0;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      mem_we      = 1'b0;
      mem_addr    = wr_ptr_q[ADDR_W-1:0];

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_edge && (bus.ctrl_data_contition == COND_STORE)) begin
                  len_d       = PTR_W'(bus.mc_data_length);
                  wr_ptr_d    = '0;
                  rd_ptr_d    = '0;
                  exhausted_d = 1'b0;
                  state_d     = STORE;
               end else if (cmd_edge && (bus.ctrl_data_contition == COND_XFER)) begin
                  mem_addr = rd_ptr_q[ADDR_W-1:0];
                  state_d  = RD_A;
               end
            end
            STORE: begin
               if (wr_ptr_q == len_q) begin
                  mc_done_d = 1'b1;
                  state_d   = IDLE;
               end else if (bus.mc_data_in_valid) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
               end
            end
            RD_A: begin
               op_a_d   = (rd_ptr_q >= len_q) ? '0 : mem_rdata;
               mem_addr = rd_ptr_p1[ADDR_W-1:0];
               state_d  = RD_B;
            end
            RD_B: begin
               op_b_d   = (rd_ptr_p1 >= len_q) ? '0 : mem_rdata;
               rd_ptr_d = (rd_ptr_p2 > len_q) ? len_q : rd_ptr_p2;
               state_d  = XFER_END;
            end
            XFER_END: begin
               mc_done_d   = 1'b1;
               exhausted_d = (rd_ptr_q == len_q);
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge mc_clk) begin
      if (mc_reset) begin
         state_q     <= IDLE;
         cond_q      <= 3'b000;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         exhausted_q <= 1'b0;
         mc_done_q   <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
      end else begin
         state_q     <= state_d;
         cond_q      <= cond_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         exhausted_q <= exhausted_d;
         mc_done_q   <= mc_done_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
      end
   end

   assign bus.mc_done      = mc_done_q;
   assign bus.mc_data_done = exhausted_q && (bus.ctrl_data_contition == COND_PROC) && bus.procc_done;
   assign bus.mc_operand_a = op_a_q;
   assign bus.mc_operand_b = op_b_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed scenario bench for memory_controller: store, transfer, data-done, abort and reset.
module tb_memory_controller;
   import mc_pkg::*;

   logic mc_clk = 1'b0;
   logic mc_reset;
   int   total = 0;
   int   bad = 0;
   logic [7:0] wtab [4];

   mc_if #(.DATA_W(8)) bus ();

   memory_controller #(
      .DATA_W (8),
      .ADDR_W (6)
   ) dut (
      .mc_clk   (mc_clk),
      .mc_reset (mc_reset),
      .bus      (bus)
   );

   always #5 mc_clk = ~mc_clk;

   task automatic step();
      @(posedge mc_clk);
      #1;
   endtask

   // Command edge is the first step; lat counts clock edges after it until mc_done.
   task automatic do_xfer(output int lat);
      lat = 0;
      bus.ctrl_data_contition = 3'b010;
      step();
      for (int c = 1; c <= 8; c++) begin
         step();
         if (lat == 0 && bus.mc_done === 1'b1) lat = c;
      end
      bus.ctrl_data_contition = 3'b000;
      step();
   endtask

   task automatic do_store(input int len, input int n, output int lat);
      lat = 0;
      bus.ctrl_data_contition = 3'b100;
      bus.mc_data_length = 6'(len);
      step();
      for (int i = 0; i < n; i++) begin
         bus.mc_data_in = wtab[i];
         bus.mc_data_in_valid = 1'b1;
         step();
      end
      bus.mc_data_in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (lat == 0 && bus.mc_done === 1'b1) lat = c;
      end
      bus.ctrl_data_contition = 3'b000;
      step();
   endtask

   task automatic test_reset();
      mc_reset = 1'b1;
      bus.ctrl_data_contition = 3'b000;
      bus.mc_data_length = 6'd0;
      bus.mc_data_in = 8'h00;
      bus.mc_data_in_valid = 1'b0;
      bus.procc_done = 1'b0;
      step();
      step();
      mc_reset = 1'b0;
      total++; if (bus.mc_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.mc_done); end
      total++; if (bus.mc_operand_a !== 8'h00) begin bad++; $display("FAIL reset_op_a got=%h want=00", bus.mc_operand_a); end
      total++; if (bus.mc_operand_b !== 8'h00) begin bad++; $display("FAIL reset_op_b got=%h want=00", bus.mc_operand_b); end
      bus.ctrl_data_contition = 3'b001;
      bus.procc_done = 1'b1;
      #1;
      total++; if (bus.mc_data_done !== 1'b0) begin bad++; $display("FAIL reset_data_done got=%b want=0", bus.mc_data_done); end
      bus.ctrl_data_contition = 3'b000;
      bus.procc_done = 1'b0;
      step();
   endtask

   task automatic test_store4();
      int early = 0;
      wtab = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus.ctrl_data_contition = 3'b100;
      bus.mc_data_length = 6'd4;
      step();
      for (int i = 0; i < 4; i++) begin
         bus.mc_data_in = wtab[i];
         bus.mc_data_in_valid = 1'b1;
         step();
         if (bus.mc_done !== 1'b0) early++;
      end
      bus.mc_data_in_valid = 1'b0;
      total++; if (early != 0) begin bad++; $display("FAIL store4_early got=%0d want=0", early); end
      step();
      total++; if (bus.mc_done !== 1'b1) begin bad++; $display("FAIL store4_done got=%b want=1", bus.mc_done); end
      step();
      total++; if (bus.mc_done !== 1'b0) begin bad++; $display("FAIL store4_pulse got=%b want=0", bus.mc_done); end
      bus.ctrl_data_contition = 3'b000;
      step();
   endtask

   task automatic test_xfer_pairs();
      int lat;
      logic [7:0] ea [2];
      logic [7:0] eb [2];
      ea = '{8'h11, 8'h33};
      eb = '{8'h22, 8'h44};
      for (int k = 0; k < 2; k++) begin
         do_xfer(lat);
         total++; if (lat != 3) begin bad++; $display("FAIL xfer%0d_lat got=%0d want=3", k, lat); end
         total++; if (bus.mc_operand_a !== ea[k]) begin bad++; $display("FAIL xfer%0d_a got=%h want=%h", k, bus.mc_operand_a, ea[k]); end
         total++; if (bus.mc_operand_b !== eb[k]) begin bad++; $display("FAIL xfer%0d_b got=%h want=%h", k, bus.mc_operand_b, eb[k]); end
      end
   endtask

   task automatic test_len3();
      int lat;
      wtab = '{8'hA1, 8'hB2, 8'h33, 8'h00};
      do_store(3, 3, lat);
      total++; if (lat != 1) begin bad++; $display("FAIL len3_store_lat got=%0d want=1", lat); end
      do_xfer(lat);
      total++; if (bus.mc_operand_a !== 8'hA1 || bus.mc_operand_b !== 8'hB2) begin
         bad++; $display("FAIL len3_first got=%h/%h want=a1/b2", bus.mc_operand_a, bus.mc_operand_b); end
      bus.ctrl_data_contition = 3'b001;
      bus.procc_done = 1'b1;
      #1;
      total++; if (bus.mc_data_done !== 1'b0) begin bad++; $display("FAIL len3_partial_done got=%b want=0", bus.mc_data_done); end
      bus.ctrl_data_contition = 3'b000;
      bus.procc_done = 1'b0;
      step();
      do_xfer(lat);
      total++; if (lat != 3) begin bad++; $display("FAIL len3_lat got=%0d want=3", lat); end
      total++; if (bus.mc_operand_a !== 8'h33) begin bad++; $display("FAIL len3_a got=%h want=33", bus.mc_operand_a); end
      total++; if (bus.mc_operand_b !== 8'h00) begin bad++; $display("FAIL len3_b got=%h want=00", bus.mc_operand_b); end
      bus.ctrl_data_contition = 3'b001;
      bus.procc_done = 1'b1;
      #1;
      total++; if (bus.mc_data_done !== 1'b1) begin bad++; $display("FAIL len3_data_done got=%b want=1", bus.mc_data_done); end
      bus.procc_done = 1'b0;
      #1;
      total++; if (bus.mc_data_done !== 1'b0) begin bad++; $display("FAIL len3_no_procc got=%b want=0", bus.mc_data_done); end
      bus.ctrl_data_contition = 3'b000;
      step();
   endtask

   task automatic test_len0();
      int lat;
      do_store(0, 0, lat);
      total++; if (lat != 1) begin bad++; $display("FAIL len0_store_lat got=%0d want=1", lat); end
      do_xfer(lat);
      total++; if (lat != 3) begin bad++; $display("FAIL len0_xfer_lat got=%0d want=3", lat); end
      total++; if (bus.mc_operand_a !== 8'h00 || bus.mc_operand_b !== 8'h00) begin
         bad++; $display("FAIL len0_ops got=%h/%h want=00/00", bus.mc_operand_a, bus.mc_operand_b); end
      bus.ctrl_data_contition = 3'b001;
      bus.procc_done = 1'b1;
      #1;
      total++; if (bus.mc_data_done !== 1'b1) begin bad++; $display("FAIL len0_data_done got=%b want=1", bus.mc_data_done); end
      bus.ctrl_data_contition = 3'b000;
      bus.procc_done = 1'b0;
      step();
   endtask

   task automatic test_undecoded();
      int pulses = 0;
      logic [2:0] codes [4];
      codes = '{3'b011, 3'b101, 3'b110, 3'b111};
      bus.mc_data_length = 6'd0;
      for (int k = 0; k < 4; k++) begin
         bus.ctrl_data_contition = codes[k];
         for (int c = 0; c < 5; c++) begin
            step();
            if (bus.mc_done === 1'b1) pulses++;
         end
         bus.ctrl_data_contition = 3'b000;
         step();
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL undecoded_done got=%0d want=0", pulses); end
   endtask

   task automatic test_gapped();
      int lat;
      int early = 0;
      bus.ctrl_data_contition = 3'b100;
      bus.mc_data_length = 6'd2;
      step();
      bus.mc_data_in = 8'hC1; bus.mc_data_in_valid = 1'b1; step();
      if (bus.mc_done !== 1'b0) early++;
      bus.mc_data_in = 8'hDD; bus.mc_data_in_valid = 1'b0; step();
      if (bus.mc_done !== 1'b0) early++;
      step();
      if (bus.mc_done !== 1'b0) early++;
      bus.mc_data_in = 8'hC2; bus.mc_data_in_valid = 1'b1; step();
      if (bus.mc_done !== 1'b0) early++;
      total++; if (early != 0) begin bad++; $display("FAIL gap_early_done got=%0d want=0", early); end
      bus.mc_data_in = 8'hEE; bus.mc_data_in_valid = 1'b1; step();
      total++; if (bus.mc_done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", bus.mc_done); end
      bus.mc_data_in_valid = 1'b0;
      bus.ctrl_data_contition = 3'b000;
      step();
      do_xfer(lat);
      total++; if (bus.mc_operand_a !== 8'hC1 || bus.mc_operand_b !== 8'hC2) begin
         bad++; $display("FAIL gap_ops got=%h/%h want=c1/c2", bus.mc_operand_a, bus.mc_operand_b); end
   endtask

   task automatic test_abort_store();
      int lat;
      int pulses = 0;
      bus.ctrl_data_contition = 3'b100;
      bus.mc_data_length = 6'd4;
      step();
      bus.ctrl_data_contition = 3'b000;
      bus.mc_data_in = 8'hEE;
      bus.mc_data_in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (bus.mc_done === 1'b1) pulses++;
      end
      bus.mc_data_in_valid = 1'b0;
      total++; if (pulses != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", pulses); end
      total++; if (bus.mc_operand_a !== 8'hC1 || bus.mc_operand_b !== 8'hC2) begin
         bad++; $display("FAIL abort_hold got=%h/%h want=c1/c2", bus.mc_operand_a, bus.mc_operand_b); end
      do_xfer(lat);
      total++; if (bus.mc_operand_a !== 8'hC1 || bus.mc_operand_b !== 8'hC2) begin
         bad++; $display("FAIL abort_kept0 got=%h/%h want=c1/c2", bus.mc_operand_a, bus.mc_operand_b); end
      do_xfer(lat);
      total++; if (bus.mc_operand_a !== 8'h33 || bus.mc_operand_b !== 8'h44) begin
         bad++; $display("FAIL abort_kept1 got=%h/%h want=33/44", bus.mc_operand_a, bus.mc_operand_b); end
   endtask

   task automatic test_reset_mid_xfer();
      int lat;
      int pulses = 0;
      wtab = '{8'h5A, 8'h6B, 8'h00, 8'h00};
      do_store(2, 2, lat);
      bus.ctrl_data_contition = 3'b010;
      step();
      step();
      mc_reset = 1'b1;
      bus.ctrl_data_contition = 3'b000;
      step();
      mc_reset = 1'b0;
      total++; if (bus.mc_operand_a !== 8'h00 || bus.mc_operand_b !== 8'h00) begin
         bad++; $display("FAIL rst_xfer_ops got=%h/%h want=00/00", bus.mc_operand_a, bus.mc_operand_b); end
      for (int c = 0; c < 5; c++) begin
         if (bus.mc_done === 1'b1) pulses++;
         step();
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL rst_xfer_done got=%0d want=0", pulses); end
      bus.ctrl_data_contition = 3'b001;
      bus.procc_done = 1'b1;
      #1;
      total++; if (bus.mc_data_done !== 1'b0) begin bad++; $display("FAIL rst_xfer_data_done got=%b want=0", bus.mc_data_done); end
      bus.ctrl_data_contition = 3'b000;
      bus.procc_done = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_store4();
      test_xfer_pairs();
      test_len3();
      test_len0();
      test_undecoded();
      test_gapped();
      test_abort_store();
      test_reset_mid_xfer();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
